// File: rtl/mesh_term_nic.sv
// Terminal NIC for one mesh router port: host TX requests are packed into router
// packets and queued in a FWFT FIFO; router ejections drain into a one-entry RX register.
module mesh_term_nic #(
    parameter int          ROWS       = 4,
    parameter int          COLUMNS    = 4,
    parameter int          PAKG_SIZE  = 32,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  BDCST      = 8'hFF,
    parameter logic [3:0]  TERM_ROW   = 4'd0,
    parameter logic [3:0]  TERM_COL   = 4'd0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [3:0]            tx_row_i,
    input  logic [3:0]            tx_col_i,
    input  logic                  tx_mode_i,
    input  logic [PAKG_SIZE-18:0] tx_payload_i,
    output logic                  pndng_o,
    output logic [PAKG_SIZE-1:0]  data_out_o,
    input  logic                  popin_i,
    input  logic                  pndng_i,
    input  logic [PAKG_SIZE-1:0]  data_in_i,
    output logic                  pop_o,
    output logic                  rx_valid_o,
    output logic [PAKG_SIZE-1:0]  rx_data_o,
    output logic                  rx_misroute_o,
    input  logic                  rx_ready_i,
    output logic [15:0]           tx_count_o,
    output logic [15:0]           rx_count_o,
    output logic [15:0]           err_count_o
);

    // state    | meaning
    // RX_EMPTY | no packet held, any pending router packet is popped
    // RX_HOLD  | packet held for host, replaced only when host accepts it
    typedef enum logic {RX_EMPTY, RX_HOLD} rx_state_t;

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PAKG_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 run_q;
    rx_state_t            rx_state;

    logic                 full, empty, push, pop_ok, empty_pop, mis_in;
    logic [3:0]           cap_row, cap_col;
    logic [PAKG_SIZE-1:0] tx_pkt;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    // run_q keeps the host and router handshakes quiet until the first edge after reset
    assign tx_ready_o = run_q && !full;
    assign push      = tx_valid_i && tx_ready_o;
    assign pop_ok    = popin_i && !empty;
    assign empty_pop = popin_i && empty;
    assign tx_pkt    = {8'h00, tx_row_i, tx_col_i, tx_mode_i, tx_payload_i};

    assign pndng_o    = !empty;
    assign data_out_o = mem[rd_ptr];

    assign cap_row = data_in_i[PAKG_SIZE-9:PAKG_SIZE-12];
    assign cap_col = data_in_i[PAKG_SIZE-13:PAKG_SIZE-16];
    // out-of-range row/col can only matter if the terminal id itself is out of range
    assign mis_in  = ({cap_row, cap_col} != BDCST) &&
                     (({cap_row, cap_col} != {TERM_ROW, TERM_COL}) ||
                      (int'(cap_row) >= ROWS) || (int'(cap_col) >= COLUMNS));
    assign pop_o   = run_q && pndng_i && ((rx_state == RX_EMPTY) || rx_ready_i);

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= tx_pkt;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            run_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tx_count_o <= '0;
        end else begin
            run_q <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr     <= rd_ptr + 1'b1;
                tx_count_o <= sat_add(tx_count_o, 2'd1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_state      <= RX_EMPTY;
            rx_valid_o    <= 1'b0;
            rx_data_o     <= '0;
            rx_misroute_o <= 1'b0;
            rx_count_o    <= '0;
            err_count_o   <= '0;
        end else begin
            if (pop_o) begin
                rx_state      <= RX_HOLD;
                rx_valid_o    <= 1'b1;
                rx_data_o     <= data_in_i;
                rx_misroute_o <= mis_in;
                rx_count_o    <= sat_add(rx_count_o, 2'd1);
            end else if ((rx_state == RX_HOLD) && rx_ready_i) begin
                rx_state   <= RX_EMPTY;
                rx_valid_o <= 1'b0;
            end
            err_count_o <= sat_add(err_count_o,
                                   {1'b0, pop_o && mis_in} + {1'b0, empty_pop});
        end
    end

endmodule

// File: tb/tb_mesh_term_nic.sv
// Bench for mesh_term_nic: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based behavioural model of the NIC.
module tb_mesh_term_nic;

    localparam int P = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          tx_valid_i = 1'b0;
    logic          tx_ready_o;
    logic [3:0]    tx_row_i = '0;
    logic [3:0]    tx_col_i = '0;
    logic          tx_mode_i = 1'b0;
    logic [P-18:0] tx_payload_i = '0;
    logic          pndng_o;
    logic [P-1:0]  data_out_o;
    logic          popin_i = 1'b0;
    logic          pndng_i = 1'b0;
    logic [P-1:0]  data_in_i = '0;
    logic          pop_o;
    logic          rx_valid_o;
    logic [P-1:0]  rx_data_o;
    logic          rx_misroute_o;
    logic          rx_ready_i = 1'b0;
    logic [15:0]   tx_count_o, rx_count_o, err_count_o;

    mesh_term_nic #(.ROWS(4), .COLUMNS(4), .PAKG_SIZE(P), .FIFO_DEPTH(16),
                    .BDCST(8'hFF), .TERM_ROW(4'd1), .TERM_COL(4'd2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .tx_row_i(tx_row_i), .tx_col_i(tx_col_i), .tx_mode_i(tx_mode_i),
        .tx_payload_i(tx_payload_i),
        .pndng_o(pndng_o), .data_out_o(data_out_o), .popin_i(popin_i),
        .pndng_i(pndng_i), .data_in_i(data_in_i), .pop_o(pop_o),
        .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_misroute_o(rx_misroute_o),
        .rx_ready_i(rx_ready_i),
        .tx_count_o(tx_count_o), .rx_count_o(rx_count_o), .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // behavioural model
    logic [P-1:0] txq[$];
    bit           m_run;
    bit           m_rxv;
    logic [P-1:0] m_rxd;
    bit           m_mis;
    int           m_txc, m_rxc, m_errc;

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic bit misf(input logic [P-1:0] pk);
        logic [7:0] d;
        d = pk[23:16];
        return (d != 8'h12) && (d != 8'hFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("tx_ready", 32'(tx_ready_o), 32'(m_run && txq.size() < 16));
        chk("pndng", 32'(pndng_o), 32'(txq.size() > 0));
        if (txq.size() > 0)
            chk("data_out", data_out_o, txq[0]);
        chk("pop", 32'(pop_o), 32'(m_run && pndng_i && (!m_rxv || rx_ready_i)));
        chk("rx_valid", 32'(rx_valid_o), 32'(m_rxv));
        if (m_rxv) begin
            chk("rx_data", rx_data_o, m_rxd);
            chk("rx_misroute", 32'(rx_misroute_o), 32'(m_mis));
        end
        chk("tx_count", 32'(tx_count_o), 32'(m_txc));
        chk("rx_count", 32'(rx_count_o), 32'(m_rxc));
        chk("err_count", 32'(err_count_o), 32'(m_errc));
    endtask

    task automatic model_edge();
        bit rdy, pushh, popok, emp, popx, mis;
        logic [P-1:0] pk;
        rdy   = m_run && (txq.size() < 16);
        pushh = tx_valid_i && rdy;
        popok = popin_i && (txq.size() > 0);
        emp   = popin_i && (txq.size() == 0);
        popx  = m_run && pndng_i && (!m_rxv || rx_ready_i);
        mis   = misf(data_in_i);
        pk    = {8'h00, tx_row_i, tx_col_i, tx_mode_i, tx_payload_i};
        if (popok) begin
            void'(txq.pop_front());
            m_txc = sat(m_txc + 1);
        end
        if (pushh)
            txq.push_back(pk);
        if (popx) begin
            m_rxv = 1'b1;
            m_rxd = data_in_i;
            m_mis = mis;
            m_rxc = sat(m_rxc + 1);
        end else if (m_rxv && rx_ready_i) begin
            m_rxv = 1'b0;
        end
        m_errc = sat(m_errc + int'(popx && mis) + int'(emp));
        m_run  = 1'b1;
    endtask

    task automatic step();
        #1 check_all();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        tx_valid_i = 1'b0;
        popin_i    = 1'b0;
        pndng_i    = 1'b0;
        rx_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        txq.delete();
        m_run = 0; m_rxv = 0; m_rxd = '0; m_mis = 0;
        m_txc = 0; m_rxc = 0; m_errc = 0;
        tx_valid_i = 1'b1; popin_i = 1'b1; pndng_i = 1'b1; rx_ready_i = 1'b1;
        #1;
        check_all();
        chk("rst_pndng", 32'(pndng_o), 32'd0);
        chk("rst_pop", 32'(pop_o), 32'd0);
        chk("rst_rx_data", rx_data_o, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_all();
        idle_inputs();
        rst_i = 1'b1;
    endtask

    function automatic logic [P-1:0] rnd_pkt();
        logic [7:0] d;
        case ($urandom_range(2))
            0:       d = 8'h12;
            1:       d = 8'hFF;
            default: d = 8'($urandom);
        endcase
        return {8'($urandom), d, 16'($urandom)};
    endfunction

    task automatic set_tx(input logic [3:0] r, input logic [3:0] c, input logic m,
                          input logic [14:0] pl);
        tx_valid_i = 1'b1; tx_row_i = r; tx_col_i = c; tx_mode_i = m; tx_payload_i = pl;
    endtask

    initial begin
        @(negedge clk_i);

        // reset release
        do_reset();
        step();
        chk("ready_after_rel", 32'(tx_ready_o), 32'd1);
        chk("pndng_after_rel", 32'(pndng_o), 32'd0);

        // single packet formatting and FWFT latency
        set_tx(4'd3, 4'd1, 1'b1, 15'h1234);
        step();
        tx_valid_i = 1'b0;
        chk("fwft_pndng", 32'(pndng_o), 32'd1);
        chk("fwft_data", data_out_o, 32'h0031_9234);
        popin_i = 1'b1;
        step();
        popin_i = 1'b0;

        // fill to full, popin on full, drain in order
        do_reset();
        step();
        for (int i = 0; i < 16; i++) begin
            set_tx(4'($urandom), 4'($urandom), 1'($urandom), 15'($urandom));
            step();
        end
        chk("full_ready", 32'(tx_ready_o), 32'd0);
        popin_i = 1'b1;
        step();
        tx_valid_i = 1'b0;
        chk("unfull_ready", 32'(tx_ready_o), 32'd1);
        chk("unfull_txcnt", 32'(tx_count_o), 32'd1);
        for (int i = 0; i < 15; i++) step();
        popin_i = 1'b0;
        chk("drain_txcnt", 32'(tx_count_o), 32'd16);
        step();

        // back-to-back receive addressed to this terminal
        do_reset();
        step();
        pndng_i = 1'b1; rx_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in_i = {8'h00, 8'h12, 16'($urandom)};
            #1 chk("b2b_pop", 32'(pop_o), 32'd1);
            step();
        end
        pndng_i = 1'b0;
        chk("b2b_rxcnt", 32'(rx_count_o), 32'd3);
        chk("b2b_mis", 32'(rx_misroute_o), 32'd0);
        step();

        // misroute then broadcast, with host stall
        do_reset();
        step();
        pndng_i = 1'b1; rx_ready_i = 1'b0;
        data_in_i = 32'hAA00_5555;
        step();
        chk("mis_flag", 32'(rx_misroute_o), 32'd1);
        chk("mis_err", 32'(err_count_o), 32'd1);
        data_in_i = 32'hBBFF_6666;
        #1 chk("stall_pop", 32'(pop_o), 32'd0);
        step();
        chk("stall_data", rx_data_o, 32'hAA00_5555);
        rx_ready_i = 1'b1;
        step();
        pndng_i = 1'b0;
        chk("bdcst_mis", 32'(rx_misroute_o), 32'd0);
        chk("bdcst_err", 32'(err_count_o), 32'd1);
        step();

        // popin on empty, then reset mid-burst
        do_reset();
        step();
        popin_i = 1'b1;
        step();
        popin_i = 1'b0;
        chk("empty_pop_err", 32'(err_count_o), 32'd1);
        chk("empty_pop_pndng", 32'(pndng_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_tx(4'd2, 4'd2, 1'b0, 15'(i));
            step();
        end
        popin_i = 1'b1;
        for (int i = 5; i < 7; i++) begin
            set_tx(4'd2, 4'd2, 1'b0, 15'(i));
            step();
        end
        do_reset();
        step();
        chk("post_rst_pndng", 32'(pndng_o), 32'd0);
        chk("post_rst_ready", 32'(tx_ready_o), 32'd1);

        // randomized traffic with varying load profiles
        for (int ph = 0; ph < 6; ph++) begin
            int p_tx, p_pop, p_pnd, p_rdy;
            p_tx  = $urandom_range(10, 95);
            p_pop = $urandom_range(5, 95);
            p_pnd = $urandom_range(10, 95);
            p_rdy = $urandom_range(10, 95);
            if (ph == 3) begin
                do_reset();
            end
            for (int c = 0; c < 600; c++) begin
                tx_valid_i   = ($urandom_range(99) < p_tx);
                tx_row_i     = 4'($urandom);
                tx_col_i     = 4'($urandom);
                tx_mode_i    = 1'($urandom);
                tx_payload_i = 15'($urandom);
                popin_i      = ($urandom_range(99) < p_pop);
                pndng_i      = ($urandom_range(99) < p_pnd);
                data_in_i    = rnd_pkt();
                rx_ready_i   = ($urandom_range(99) < p_rdy);
                step();
            end
        end
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
